// File: rtl/fm_buffer_reader_pkg.sv
// Shared types and defaults for the feature-map buffer read sequencer.
// Holds FSM encodings, the beat bundle carried down the latency pipe, and width defaults.
package fm_buffer_reader_pkg;

  localparam int unsigned FM_ADDR_BITWIDTH = 8;
  localparam int unsigned NUM_KERNELS_DEF  = 2;
  localparam int unsigned SEL_W_DEF =
    (NUM_KERNELS_DEF > 1) ? $clog2(NUM_KERNELS_DEF) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_t;

endpackage

// File: rtl/fm_buffer_reader_read_valid_pipe.sv
// Delay line matching RAM + read-mux latency for the {valid, first, last} beat tag.
// Ports: clock, reset (sync, active-high), beat_i (issued tag), beat_o (tag aligned to data).
module fm_buffer_reader_read_valid_pipe
  import fm_buffer_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  beat_t beat_i,
  output beat_t beat_o
);

  beat_t pipe_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= beat_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign beat_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fm_buffer_reader.sv
// Read-side sequencer: sweeps every address x kernel once the buffer is full.
// Ports: clock, reset, start in; rd_addr, ram_select, rd_valid/first/last, busy, done out.
module fm_buffer_reader
  import fm_buffer_reader_pkg::*;
#(
  parameter int unsigned FM_DEPTH    = 256,
  parameter int unsigned ADDR_W      = FM_ADDR_BITWIDTH,
  parameter int unsigned NUM_KERNELS = NUM_KERNELS_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [SEL_W-1:0]  ram_select,
  output logic              rd_valid,
  output logic              rd_first,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  beat_t issue, beat_out;
  logic  last_sel, last_pair;

  assign last_sel  = (sel_q == SEL_W'(NUM_KERNELS - 1));
  assign last_pair = last_sel && (addr_q == ADDR_W'(FM_DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  // Counters fall back to zero whenever the next cycle is not an issue cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    sel_d   = '0;
    issue   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        issue.valid = 1'b1;
        issue.first = (addr_q == '0) && (sel_q == '0);
        issue.last  = last_pair;
        if (last_pair) begin
          state_d = S_DRAIN;
        end else if (last_sel) begin
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          addr_d = addr_q;
          sel_d  = sel_q + SEL_W'(1);
        end
      end
      S_DRAIN: begin
        if (beat_out.last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  fm_buffer_reader_read_valid_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_pipe (
    .clock  (clock),
    .reset  (reset),
    .beat_i (issue),
    .beat_o (beat_out)
  );

  assign rd_addr    = addr_q;
  assign ram_select = sel_q;
  assign rd_valid   = beat_out.valid;
  assign rd_first   = beat_out.first;
  assign rd_last    = beat_out.last;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
